// File: rtl/pipa_moding_gen.sv
// pipa_moding_gen: per-axis PIPA plus/minus pulse spoofer with a runtime-programmable moding ratio.
// Build option PIPA_FAIL_INJECT_EN adds fail_inj, forcing both PIPA lines of an axis to follow PIPDAT.
module pipa_moding_gen #(
    parameter int AXES      = 3,
    parameter int CNT_W     = 4,
    parameter int PLUS_DEF  = 3,
    parameter int MINUS_DEF = 3,
    parameter int NET_W     = 16
) (
    input  logic                  SIM_CLK,
    input  logic                  SIM_RST,
    input  logic                  PIPASW,
    input  logic                  PIPDAT,
    input  logic                  cfg_wr,
    input  logic [2:0]            cfg_axis,
    input  logic [CNT_W-1:0]      cfg_plus,
    input  logic [CNT_W-1:0]      cfg_minus,
    input  logic                  cnt_clr,
`ifdef PIPA_FAIL_INJECT_EN
    input  logic [AXES-1:0]       fail_inj,
`endif
    output logic [AXES-1:0]       PIPAp,
    output logic [AXES-1:0]       PIPAm,
    output logic [AXES-1:0]       wrap,
    output logic [AXES*NET_W-1:0] net_count
);
    localparam logic [NET_W-1:0] NET_MAX  = {1'b0, {(NET_W-1){1'b1}}};
    localparam logic [NET_W-1:0] NET_MIN  = {1'b1, {(NET_W-1){1'b0}}};
    localparam logic [NET_W-1:0] NET_ONE  = {{(NET_W-1){1'b0}}, 1'b1};
    localparam logic [NET_W-1:0] NET_ZERO = {NET_W{1'b0}};
    localparam logic [CNT_W:0]   PH_ONE   = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   PH_ZERO  = {(CNT_W+1){1'b0}};

    logic pipasw_q;
    logic pipdat_q;
    logic adv_s;
    logic pdat_rise_s;

    assign adv_s       = PIPASW & ~pipasw_q;
    assign pdat_rise_s = PIPDAT & ~pipdat_q;

    // Edge-detect history for the two AGC strobes
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            pipasw_q <= 1'b0;
            pipdat_q <= 1'b0;
        end else begin
            pipasw_q <= PIPASW;
            pipdat_q <= PIPDAT;
        end
    end

    for (genvar i = 0; i < AXES; i++) begin : g_axis
        logic [CNT_W-1:0] p_q, p_d, m_q, m_d, ps_q, ps_d, ms_q, ms_d;
        logic [CNT_W:0]   ph_q, ph_d;
        logic [NET_W-1:0] net_q, net_d;
        logic             wrap_q, wrap_d;
        logic [CNT_W:0]   len_s;
        logic             en_s;
        logic             plus_s;
        logic             sel_s;

        assign len_s  = {1'b0, p_q} + {1'b0, m_q};
        assign en_s   = (len_s != PH_ZERO);
        assign plus_s = (ph_q < {1'b0, p_q});
        assign sel_s  = cfg_wr & (cfg_axis == 3'(i));

        // Next-state: phase advance and wrap-time config swap, immediate load of a disabled axis, net count
        always_comb begin
            p_d    = p_q;
            m_d    = m_q;
            ph_d   = ph_q;
            wrap_d = 1'b0;
            net_d  = net_q;
            if (en_s && adv_s) begin
                if (ph_q == len_s - PH_ONE) begin
                    ph_d   = PH_ZERO;
                    wrap_d = 1'b1;
                    p_d    = ps_q;
                    m_d    = ms_q;
                end else begin
                    ph_d = ph_q + PH_ONE;
                end
            end else if (sel_s && !en_s) begin
                p_d  = cfg_plus;
                m_d  = cfg_minus;
                ph_d = PH_ZERO;
            end else begin
                ph_d = ph_q;
            end

            if (sel_s) begin
                ps_d = cfg_plus;
                ms_d = cfg_minus;
            end else begin
                ps_d = ps_q;
                ms_d = ms_q;
            end

            if (cnt_clr) begin
                net_d = NET_ZERO;
            end else if (pdat_rise_s && en_s) begin
                if (plus_s) begin
                    net_d = (net_q != NET_MAX) ? net_q + NET_ONE : net_q;
                end else begin
                    net_d = (net_q != NET_MIN) ? net_q - NET_ONE : net_q;
                end
            end else begin
                net_d = net_q;
            end
        end

        // Per-axis state registers
        always_ff @(posedge SIM_CLK) begin
            if (SIM_RST) begin
                p_q    <= CNT_W'(PLUS_DEF);
                m_q    <= CNT_W'(MINUS_DEF);
                ps_q   <= CNT_W'(PLUS_DEF);
                ms_q   <= CNT_W'(MINUS_DEF);
                ph_q   <= PH_ZERO;
                net_q  <= NET_ZERO;
                wrap_q <= 1'b0;
            end else begin
                p_q    <= p_d;
                m_q    <= m_d;
                ps_q   <= ps_d;
                ms_q   <= ms_d;
                ph_q   <= ph_d;
                net_q  <= net_d;
                wrap_q <= wrap_d;
            end
        end

        // PIPDAT passes straight through so the AGC sees its own pulse width
`ifdef PIPA_FAIL_INJECT_EN
        assign PIPAp[i] = fail_inj[i] ? PIPDAT : (PIPDAT & plus_s & en_s);
        assign PIPAm[i] = fail_inj[i] ? PIPDAT : (PIPDAT & ~plus_s & en_s);
`else
        assign PIPAp[i] = PIPDAT & plus_s & en_s;
        assign PIPAm[i] = PIPDAT & ~plus_s & en_s;
`endif
        assign wrap[i]                      = wrap_q;
        assign net_count[i*NET_W +: NET_W] = net_q;
    end
endmodule
